// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: state encoding and default frame geometry.
// The matching receiver uses the same defaults.
package serial_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Counter width for a 0..range_n-1 count, never narrower than one bit.
    function automatic int count_width(input int range_n);
        return (range_n > 1) ? $clog2(range_n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: tick marks the last cycle of each bit while enabled.
// The count is held at zero whenever enable is low.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int                   TW   = count_width(CLKS_PER_BIT);
    localparam logic [TW-1:0]        LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data,
// optional even parity, stop bit, each held for CLKS_PER_BIT cycles.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int            CW       = count_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    state_t                state;
    state_t                state_next;
    logic                  tick;
    logic                  accept;
    logic                  timer_en;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  parity_bit;
    logic [CW-1:0]         bit_count;

    assign accept   = valid && ready;
    assign timer_en = (state != IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (timer_en),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assigned first so no path through the case leaves a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (tick)   state_next = DATA;
            DATA: begin
                if (tick && (bit_count == LAST_BIT)) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY:  if (tick)   state_next = STOP;
            STOP:    if (tick)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx    = 1'b1;
        ready = 1'b0;
        busy  = 1'b1;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            PARITY:  tx = parity_bit;
            STOP:    tx = 1'b1;
            default: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
        endcase
    end

    // Parity is taken at acceptance so later shifting cannot disturb it.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_count  <= '0;
            done       <= 1'b0;
        end else begin
            done <= (state == STOP) && tick;
            if (accept) begin
                shreg      <= data_in;
                parity_bit <= ^data_in;
                bit_count  <= '0;
            end else if ((state == DATA) && tick) begin
                shreg     <= shreg >> 1;
                bit_count <= (bit_count == LAST_BIT) ? '0 : bit_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (plain, parity, one clock per bit) driven
// from one sequence; per-instance monitors rebuild frames and score them against a queue.
module tb_serial_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       valid   [3];
    logic [7:0] data_in [3];
    logic       ready_w [3];
    logic       tx_w    [3];
    logic       busy_w  [3];
    logic       done_w  [3];

    always #5 clock = ~clock;

    typedef struct {
        int          k;
        logic [15:0] bits;
        int          nbits;
    } frame_t;

    frame_t sb[$];
    int     n_checks;
    int     n_errors;
    int     done_cnt    [3];
    int     frames_seen [3];
    int     last_done   [3];
    int     last_gap    [3];

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (
        .clock(clock), .reset(reset), .data_in(data_in[0]), .valid(valid[0]),
        .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (
        .clock(clock), .reset(reset), .data_in(data_in[1]), .valid(valid[1]),
        .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut2 (
        .clock(clock), .reset(reset), .data_in(data_in[2]), .valid(valid[2]),
        .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference frame, bit 0 first on the line.
    function automatic frame_t make_frame(input int k, input logic [7:0] d, input int p);
        frame_t f;
        f.k     = k;
        f.bits  = '0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
        if (p != 0) f.bits[9] = ^d;
        f.nbits = 10 + p;
        f.bits[f.nbits-1] = 1'b1;
        return f;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam int C  = (g == 2) ? 1 : 4;
        localparam int P  = (g == 1) ? 1 : 0;
        localparam int NB = 10 + P;

        logic        smp [64];
        int          cyc;
        bit          in_f;
        int          clkcnt;
        bit          stable;
        logic [15:0] obs;
        frame_t      e;

        initial begin
            forever begin
                @(negedge clock);
                clkcnt++;
                if (done_w[g] === 1'b1) done_cnt[g]++;
                if (reset === 1'b1) begin
                    in_f = 1'b0;
                end else if (!in_f) begin
                    if (busy_w[g] === 1'b1) begin
                        in_f        = 1'b1;
                        last_gap[g] = clkcnt - last_done[g];
                        smp[0]      = tx_w[g];
                        cyc         = 1;
                        check("start_ready", 32'(ready_w[g]), 32'd0);
                    end
                end else if (busy_w[g] === 1'b1) begin
                    if (cyc < 64) smp[cyc] = tx_w[g];
                    cyc++;
                end else begin
                    in_f         = 1'b0;
                    last_done[g] = clkcnt;
                    check("frame_len",  32'(cyc),       32'(NB * C));
                    check("done_pulse", 32'(done_w[g]), 32'd1);
                    check("idle_tx",    32'(tx_w[g]),   32'd1);
                    check("idle_ready", 32'(ready_w[g]), 32'd1);
                    stable = 1'b1;
                    obs    = '0;
                    if (cyc == NB * C) begin
                        for (int b = 0; b < NB; b++) begin
                            obs[b] = smp[b*C];
                            for (int j = 0; j < C; j++)
                                if (smp[b*C+j] !== smp[b*C]) stable = 1'b0;
                        end
                    end
                    check("bit_stable", 32'(stable), 32'd1);
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("sb_inst", 32'(e.k), 32'(g));
                        check("frame",   32'(obs), 32'(e.bits));
                    end
                    frames_seen[g]++;
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d, input int p, input bit hold);
        int n;
        @(negedge clock);
        data_in[k] = d;
        valid[k]   = 1'b1;
        sb.push_back(make_frame(k, d, p));
        n = 0;
        while (!ready_w[k] && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        if (!hold) valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy_w[k] && n < 500);
        if (n >= 500) check("idle_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int f0, d0;

        // Reset held with a pending word: nothing may start.
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid[k]   = 1'b1;
            data_in[k] = 8'hFF;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_tx",    32'(tx_w[k]),    32'd1);
            check("rst_ready", 32'(ready_w[k]), 32'd1);
            check("rst_busy",  32'(busy_w[k]),  32'd0);
            check("rst_done",  32'(done_w[k]),  32'd0);
        end
        @(negedge clock);
        for (int k = 0; k < 3; k++) valid[k] = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clock);
        for (int k = 0; k < 3; k++) check("rst_nostart", 32'(busy_w[k]), 32'd0);

        // Single frame, no parity.
        send(0, 8'hA5, 0, 1'b0);
        wait_idle(0);
        check("t2_frames", 32'(frames_seen[0]), 32'd1);
        check("t2_dones",  32'(done_cnt[0]),    32'd1);

        // Parity frame.
        send(1, 8'h07, 1, 1'b0);
        wait_idle(1);
        check("t3_frames", 32'(frames_seen[1]), 32'd1);
        check("t3_dones",  32'(done_cnt[1]),    32'd1);

        // Back-to-back with valid held high.
        send(0, 8'h00, 0, 1'b1);
        send(0, 8'hFF, 0, 1'b0);
        wait_idle(0);
        check("t4_gap",    32'(last_gap[0]),    32'd1);
        check("t4_frames", 32'(frames_seen[0]), 32'd3);
        check("t4_dones",  32'(done_cnt[0]),    32'd3);

        // Reset during data bit 3 aborts the frame.
        f0 = frames_seen[0];
        send(0, 8'h5A, 0, 1'b0);
        repeat (17) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("t5_tx",    32'(tx_w[0]),    32'd1);
        check("t5_ready", 32'(ready_w[0]), 32'd1);
        check("t5_busy",  32'(busy_w[0]),  32'd0);
        check("t5_done",  32'(done_w[0]),  32'd0);
        check("t5_sb",    32'(sb.size()),  32'd1);
        if (sb.size() > 0) void'(sb.pop_back());
        d0 = done_cnt[0];
        repeat (10) @(negedge clock);
        check("t5_no_done",   32'(done_cnt[0]),    32'(d0));
        check("t5_no_frame",  32'(frames_seen[0]), 32'(f0));
        send(0, 8'h3C, 0, 1'b0);
        wait_idle(0);
        check("t5_resend", 32'(frames_seen[0]), 32'(f0 + 1));

        // valid and data_in disturbed mid-frame must be ignored.
        f0 = frames_seen[0];
        d0 = done_cnt[0];
        send(0, 8'h66, 0, 1'b0);
        repeat (6) @(posedge clock);
        #1;
        valid[0]   = 1'b1;
        data_in[0] = 8'h99;
        @(posedge clock);
        #1 valid[0] = 1'b0;
        wait_idle(0);
        repeat (10) @(negedge clock);
        check("t6_idle",   32'(busy_w[0]),      32'd0);
        check("t6_frames", 32'(frames_seen[0]), 32'(f0 + 1));
        check("t6_dones",  32'(done_cnt[0]),    32'(d0 + 1));

        // Same abuse at one clock per bit.
        f0 = frames_seen[2];
        send(2, 8'h81, 0, 1'b0);
        @(posedge clock);
        #1;
        valid[2]   = 1'b1;
        data_in[2] = 8'h99;
        @(posedge clock);
        #1 valid[2] = 1'b0;
        wait_idle(2);
        repeat (10) @(negedge clock);
        check("t6b_idle",   32'(busy_w[2]),      32'd0);
        check("t6b_frames", 32'(frames_seen[2]), 32'(f0 + 1));

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
